// File: rtl/cacheline_adaptor.sv
// Bridges a line-wide cache memory port to a fixed-length burst memory port.
// Writes serialize a latched line into beats; reads assemble beats into a line.
module cacheline_adaptor #(
  parameter int unsigned LineWidth  = 256,
  parameter int unsigned BurstWidth = 64,
  parameter int unsigned AddrWidth  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [AddrWidth-1:0]  address_i,
  input  logic [LineWidth-1:0]  line_i,
  output logic [LineWidth-1:0]  line_o,
  output logic                  resp_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [AddrWidth-1:0]  address_o,
  output logic [BurstWidth-1:0] burst_o,
  input  logic [BurstWidth-1:0] burst_i,
  input  logic                  resp_i
);

  localparam int unsigned Beats = LineWidth / BurstWidth;
  localparam int unsigned OffW  = $clog2(LineWidth / 8);
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);
  localparam logic [AddrWidth-1:0] OffMask = AddrWidth'((64'd1 << OffW) - 64'd1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [LineWidth-1:0]  wbuf_q, wbuf_d;
  logic [LineWidth-1:0]  line_q, line_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  resp_q, resp_d;
  logic [BurstWidth-1:0] burst_q, burst_d;
  logic                  accept_c;
  logic                  beat_c;

  assign accept_c = (state_q == StIdle) && (read_i || write_i);
  assign beat_c   = resp_i && ((state_q == StRead) || (state_q == StWrite));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and beat counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (write_i) begin
          state_d = StWrite;
          cnt_d   = '0;
        end else if (read_i) begin
          state_d = StRead;
          cnt_d   = '0;
        end
      end
      StRead, StWrite: begin
        if (resp_i) begin
          if (cnt_q == LastBeat) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: address latch, write buffer, read-line assembly
  always_comb begin
    addr_d = addr_q;
    wbuf_d = wbuf_q;
    line_d = line_q;
    if (accept_c) begin
      addr_d = address_i & ~OffMask;
      if (write_i) begin
        wbuf_d = line_i;
      end
    end
    if (beat_c && (state_q == StRead)) begin
      line_d[32'(cnt_q) * BurstWidth +: BurstWidth] = burst_i;
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    read_d  = (state_d == StRead);
    write_d = (state_d == StWrite);
    resp_d  = (state_d == StDone);
    burst_d = '0;
    if (state_d == StWrite) begin
      burst_d = wbuf_d[32'(cnt_d) * BurstWidth +: BurstWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
      burst_q <= burst_d;
    end
  end

  assign line_o    = line_q;
  assign resp_o    = resp_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign address_o = addr_q;
  assign burst_o   = burst_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, stalls, writes, eviction/refill,
// mid-burst reset and spurious/simultaneous request handling.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i, write_i, resp_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o, burst_i;

  int tests_run = 0;
  int tests_failed = 0;
  int resp_cnt = 0;
  int overlap_cnt = 0;
  int resp_base;

  logic [63:0] rb [4];
  logic [63:0] sb [4];
  logic [63:0] eb [4];
  logic [63:0] wb [4];
  logic [1:0]  stall_pat [7];

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .address_o (address_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_o) resp_cnt++;
    if (read_o && write_o) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " read_o"}, 256'(read_o), 256'd0);
    check({tag, " write_o"}, 256'(write_o), 256'd0);
    check({tag, " resp_o"}, 256'(resp_o), 256'd0);
    check({tag, " burst_o"}, 256'(burst_o), 256'd0);
  endtask

  initial begin
    rb[0] = 64'hA0A0A0A0A0A0A0A0; rb[1] = 64'hA1A1A1A1A1A1A1A1;
    rb[2] = 64'hA2A2A2A2A2A2A2A2; rb[3] = 64'hA3A3A3A3A3A3A3A3;
    sb[0] = 64'hB0B0B0B0B0B0B0B0; sb[1] = 64'hB1B1B1B1B1B1B1B1;
    sb[2] = 64'hB2B2B2B2B2B2B2B2; sb[3] = 64'hB3B3B3B3B3B3B3B3;
    eb[0] = 64'hE0E0E0E0E0E0E0E0; eb[1] = 64'hE1E1E1E1E1E1E1E1;
    eb[2] = 64'hE2E2E2E2E2E2E2E2; eb[3] = 64'hE3E3E3E3E3E3E3E3;
    wb[0] = 64'h1111111111111111; wb[1] = 64'h2222222222222222;
    wb[2] = 64'h3333333333333333; wb[3] = 64'h4444444444444444;
    stall_pat[0] = 2'd1; stall_pat[1] = 2'd0; stall_pat[2] = 2'd0; stall_pat[3] = 2'd1;
    stall_pat[4] = 2'd1; stall_pat[5] = 2'd0; stall_pat[6] = 2'd1;

    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    step(); step();
    check_idle_outputs("reset");
    check("reset line_o", line_o, 256'd0);
    check("reset address_o", 256'(address_o), 256'd0);
    rst = 1'b0;
    step();

    // Read, no stalls
    read_i = 1'b1; address_i = 32'h1234_5678;
    step();
    check("rd address_o", 256'(address_o), 256'h1234_5660);
    for (int i = 0; i < 4; i++) begin
      check("rd read_o", 256'(read_o), 256'd1);
      check("rd resp_o low", 256'(resp_o), 256'd0);
      resp_i = 1'b1; burst_i = rb[i];
      step();
    end
    resp_i = 1'b0; burst_i = '0;
    check("rd resp_o", 256'(resp_o), 256'd1);
    check("rd read_o drop", 256'(read_o), 256'd0);
    check("rd line_o", line_o, {rb[3], rb[2], rb[1], rb[0]});
    check("rd line_o literal", line_o,
          256'hA3A3A3A3A3A3A3A3_A2A2A2A2A2A2A2A2_A1A1A1A1A1A1A1A1_A0A0A0A0A0A0A0A0);
    step();
    read_i = 1'b0;
    check("rd resp_o one cycle", 256'(resp_o), 256'd0);
    step();

    // Read with stalls: pattern 1,0,0,1,1,0,1
    read_i = 1'b1; address_i = 32'h1234_5678;
    step();
    begin
      int k = 0;
      for (int c = 0; c < 7; c++) begin
        check("st read_o", 256'(read_o), 256'd1);
        check("st resp_o low", 256'(resp_o), 256'd0);
        resp_i = stall_pat[c][0];
        burst_i = resp_i ? sb[k] : 64'hDEAD_BEEF_DEAD_BEEF;
        if (resp_i) k++;
        step();
      end
    end
    resp_i = 1'b0;
    check("st resp_o", 256'(resp_o), 256'd1);
    check("st line_o", line_o, {sb[3], sb[2], sb[1], sb[0]});
    resp_i = 1'b1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    read_i = 1'b0;
    check("done spurious resp_o", 256'(resp_o), 256'd0);
    check("done spurious read_o", 256'(read_o), 256'd0);
    step();
    check_idle_outputs("idle spurious");
    check("idle spurious line_o", line_o, {sb[3], sb[2], sb[1], sb[0]});
    resp_i = 1'b0;
    step();

    // Eviction (write) then refill (read)
    resp_base = resp_cnt;
    write_i = 1'b1; address_i = 32'h0000_ABFF;
    line_i = {wb[3], wb[2], wb[1], wb[0]};
    step();
    line_i = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    check("wr address_o", 256'(address_o), 256'h0000_ABE0);
    for (int i = 0; i < 4; i++) begin
      check("wr write_o", 256'(write_o), 256'd1);
      check("wr burst_o", 256'(burst_o), 256'(wb[i]));
      resp_i = 1'b1;
      step();
    end
    resp_i = 1'b0;
    check("wr write_o drop", 256'(write_o), 256'd0);
    check("wr resp_o", 256'(resp_o), 256'd1);
    check("wr burst_o zero", 256'(burst_o), 256'd0);
    step();
    write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_C040;
    step();
    check("ref read_o no bubble", 256'(read_o), 256'd1);
    check("ref address_o", 256'(address_o), 256'h0000_C040);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = rb[3 - i];
      step();
    end
    resp_i = 1'b0;
    check("ref resp_o", 256'(resp_o), 256'd1);
    check("ref line_o", line_o, {rb[0], rb[1], rb[2], rb[3]});
    step();
    read_i = 1'b0;
    step();
    check("evict refill resp pulses", 256'(resp_cnt - resp_base), 256'd2);

    // Reset mid-read after two beats; held request restarts from beat 0
    read_i = 1'b1; address_i = 32'h0BAD_F00D;
    step();
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = sb[i];
      step();
    end
    resp_i = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("midrst");
    check("midrst line_o", line_o, 256'd0);
    check("midrst address_o", 256'(address_o), 256'd0);
    address_i = 32'h0000_1020;
    step();
    check("midrst restart read_o", 256'(read_o), 256'd1);
    check("midrst restart address_o", 256'(address_o), 256'h0000_1020);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = eb[i];
      step();
    end
    resp_i = 1'b0;
    check("midrst resp_o", 256'(resp_o), 256'd1);
    check("midrst line_o", line_o, {eb[3], eb[2], eb[1], eb[0]});
    step();
    read_i = 1'b0;
    step();

    // Simultaneous requests: write wins
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_2000;
    line_i = {wb[0], wb[1], wb[2], wb[3]};
    step();
    check("sim write_o", 256'(write_o), 256'd1);
    check("sim read_o", 256'(read_o), 256'd0);
    for (int i = 0; i < 4; i++) begin
      check("sim burst_o", 256'(burst_o), 256'(wb[3 - i]));
      resp_i = 1'b1;
      step();
    end
    resp_i = 1'b0;
    check("sim resp_o", 256'(resp_o), 256'd1);
    check("sim line_o untouched", line_o, {eb[3], eb[2], eb[1], eb[0]});
    step();
    read_i = 1'b0; write_i = 1'b0;
    step();
    check("read_o write_o overlap", 256'(overlap_cnt), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the cache controller's line-wide physical-memory port (one full line per request, level request held until a one-cycle response) to a narrow burst-oriented main-memory port. The adaptor is the responder for the cache's `pmem_read`/`pmem_write`/`pmem_resp` handshake. It is the initiator of fixed-length bursts toward memory. On a write it serializes a latched line into beats; on a read it assembles beats into a line. It sits between the cache datapath/controller and the memory model or arbiter.

## Interface
- `LineWidth`, 256, cache line width in bits.
- `BurstWidth`, 64, memory beat width in bits; `LineWidth` is an integer multiple of it.
- `AddrWidth`, 32, address width in bits.
- Beats = `LineWidth/BurstWidth` (4 by default). The offset field is `log2(LineWidth/8)` bits (5 by default).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `read_i` in 1: cache line-read request; level, held until `resp_o`.
- `write_i` in 1: cache line-write request; level, held until `resp_o`.
- `address_i` in `AddrWidth`: line address from the cache.
- `line_i` in `LineWidth`: line to write; sampled at acceptance.
- `line_o` out `LineWidth`: assembled read line.
- `resp_o` out 1: one-cycle completion pulse to the cache.
- `read_o` out 1: burst read request to memory.
- `write_o` out 1: burst write request to memory.
- `address_o` out `AddrWidth`: line-aligned burst address.
- `burst_o` out `BurstWidth`: current write beat.
- `burst_i` in `BurstWidth`: read beat data, valid when `resp_i`=1.
- `resp_i` in 1: memory beat strobe; one beat is transferred per cycle it is high.

## Operation
- **States:** IDLE, READ, WRITE, DONE. A beat counter tracks 0..Beats-1.
- **IDLE**
  - If `write_i`=1, latch `line_i` into the write buffer and go to WRITE.
  - Else if `read_i`=1, go to READ.
  - In both cases, latch `address_i` with the offset bits forced to 0 into `address_o`, and clear the counter.
  - `write_i` has priority when both requests are high.
- **READ**
  - `read_o`=1.
  - On each cycle with `resp_i`=1, store `burst_i` into `line_o[cnt*BurstWidth +: BurstWidth]` and increment the counter. Beat 0 is the least-significant beat.
  - On the beat where cnt=Beats-1, go to DONE and wrap the counter to 0.
  - Cycles with `resp_i`=0 are stalls: nothing changes.
- **WRITE**
  - `write_o`=1 and `burst_o` = buffer beat `cnt`.
  - On each `resp_i`=1, advance the counter.
  - After the beat where cnt=Beats-1 is accepted, go to DONE.
- **DONE**
  - `resp_o`=1 for exactly one cycle, then go unconditionally to IDLE.
  - `read_i`/`write_i` are ignored in DONE.
- **Outside READ/WRITE:** `read_o`=`write_o`=0, `burst_o`=0, and `resp_i` is ignored.
- **`line_o`** is registered. It holds the last completed read line until the next read overwrites it beat by beat. It is valid in DONE of a read.
- **`address_o`** holds its latched value until the next acceptance.
- **Reset** (any state, including mid-burst):
  - State returns to IDLE and the counter to 0.
  - `resp_o`=`read_o`=`write_o`=0, and `line_o`, `burst_o`, `address_o` and the write buffer are all 0.
  - A partial line is discarded.
  - The cycle after reset deasserts, a held request is accepted fresh.

## Timing
- Acceptance takes 1 cycle. If the request is seen in IDLE at cycle 0, then `read_o`/`write_o` are high from cycle 1.
- With memory strobing `resp_i` in cycles 1+d..Beats+d (d ≥ 0, contiguous), `resp_o` is high in cycle Beats+d+1. Minimum request-to-`resp_o` is Beats+1 cycles (5 by default).
- Each stall cycle of `resp_i`=0 inside a burst adds one cycle.
- `read_o`/`write_o` drop in the DONE cycle; memory sees them low the cycle after the last beat.
- Back-to-back requests:
  - The cache drops its request the cycle after `resp_o` and may raise the other request in that same cycle. That is the IDLE cycle, so it is accepted immediately.
  - An eviction followed by a refill is therefore 2×(Beats+1)+1 cycles minimum.
- `burst_o` changes only on the clock edge after an accepted beat. It is stable while `resp_i`=0.

## Test plan
- **Read, no stalls:** `read_i`=1 at addr 0x1234_5678. Memory answers `resp_i` in cycles 1–4 with 0xA0..,0xA1..,0xA2..,0xA3...
  - `address_o`=0x1234_5660.
  - `resp_o` high only in cycle 5.
  - `line_o`={A3,A2,A1,A0}.
- **Read with stalls:** same request, `resp_i` pattern 1,0,0,1,1,0,1.
  - Four beats are captured in order.
  - `resp_o` is high in the cycle after the 7th strobe cycle.
  - `read_o` stays high throughout.
- **Write:** `line_i`={D,C,B,A}, `write_i`=1, `resp_i` contiguous.
  - `burst_o` = A,B,C,D in cycles 1–4.
  - `write_o` is high in cycles 1–4 and low in cycle 5.
  - `resp_o` is high in cycle 5.
  - `line_i` changing after acceptance has no effect.
- **Eviction then refill:** `write_i` completes, then `read_i` is raised in the IDLE cycle after `resp_o`.
  - Read accepted with no extra bubble.
  - Exactly two `resp_o` pulses.
  - `read_o` and `write_o` are never high together.
- **Reset mid-read:** assert `rst` after 2 beats.
  - The next cycle, all outputs are 0 and the state is IDLE.
  - A held `read_i` restarts with beat 0.
  - The final `line_o` contains only the new beats.
- **Spurious and simultaneous inputs:**
  - `resp_i` pulsed in IDLE/DONE → no state change, no `resp_o`.
  - `read_i`=`write_i`=1 → a write burst is performed.
